// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

    // Default bus widths.
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Requester identifiers.
    typedef logic req_id_t;
    localparam req_id_t REQ_IF = 1'b0;   // instruction fetch port (read-only)
    localparam req_id_t REQ_DM = 1'b1;   // data port (load/store)

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, status and RAM-side signals for mem_port_arbiter.
// slave = the arbiter, master = the requesters plus the RAM.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // Fetch port
    logic              I_IF_REQ;
    logic [ADDR_W-1:0] I_IF_ADDR;
    logic              O_IF_ACK;
    logic [DATA_W-1:0] O_IF_DATA;

    // Data port
    logic              I_DM_REQ;
    logic              I_DM_WE;
    logic [ADDR_W-1:0] I_DM_ADDR;
    logic [DATA_W-1:0] I_DM_WDATA;
    logic              O_DM_ACK;
    logic [DATA_W-1:0] O_DM_RDATA;

    // RAM side
    logic              O_MEM_WE;
    logic [ADDR_W-1:0] O_MEM_ADDR;
    logic [DATA_W-1:0] O_MEM_DATA;
    logic [DATA_W-1:0] I_MEM_DATA;

    // Status
    logic              O_BUSY;

    modport slave (
        input  I_IF_REQ, I_IF_ADDR,
        input  I_DM_REQ, I_DM_WE, I_DM_ADDR, I_DM_WDATA,
        input  I_MEM_DATA,
        output O_IF_ACK, O_IF_DATA,
        output O_DM_ACK, O_DM_RDATA,
        output O_MEM_WE, O_MEM_ADDR, O_MEM_DATA,
        output O_BUSY
    );

    modport master (
        output I_IF_REQ, I_IF_ADDR,
        output I_DM_REQ, I_DM_WE, I_DM_ADDR, I_DM_WDATA,
        output I_MEM_DATA,
        input  O_IF_ACK, O_IF_DATA,
        input  O_DM_ACK, O_DM_RDATA,
        input  O_MEM_WE, O_MEM_ADDR, O_MEM_DATA,
        input  O_BUSY
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way combinational pick between fetch and data ports with a
// registered last-grant pointer. RR_EN=1 alternates on ties, RR_EN=0
// always gives a tie to the data port.
module rr_arb2
    import mem_port_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic    I_CLK,
    input  logic    I_RST_N,
    input  logic    req_if_i,
    input  logic    req_dm_i,
    input  logic    grant_en_i,   // sequencer accepts the current pick
    output logic    valid_o,
    output req_id_t pick_o
);

    req_id_t last_q;

    // Choose a port; on a tie pick the one not served most recently (RR) or the data port.
    always_comb begin
        valid_o = req_if_i | req_dm_i;
        pick_o  = REQ_IF;
        if (req_if_i && req_dm_i) begin
            if (RR_EN) begin
                pick_o = (last_q == REQ_IF) ? REQ_DM : REQ_IF;
            end else begin
                pick_o = REQ_DM;
            end
        end else if (req_dm_i) begin
            pick_o = REQ_DM;
        end
    end

    // Remember the last granted port; reset says "fetch last" so data wins the first tie.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            last_q <= REQ_IF;
        end else if (grant_en_i && valid_o) begin
            last_q <= pick_o;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a read-only fetch port and a load/store data port onto one
// single-port RAM that samples on the falling clock edge. Each access is
// IDLE -> ACCESS -> DONE, giving a fixed three-cycle turnaround.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                I_CLK,
    input  logic                I_RST_N,
    mem_port_arbiter_if.slave   bus
);

    state_e            state_q,    state_d;
    req_id_t           grant_q,    grant_d;
    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              if_ack_q,   if_ack_d;
    logic              dm_ack_q,   dm_ack_d;
    logic [DATA_W-1:0] if_data_q,  if_data_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic    arb_valid;
    logic    arb_en;
    req_id_t arb_pick;

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .I_CLK      (I_CLK),
        .I_RST_N    (I_RST_N),
        .req_if_i   (bus.I_IF_REQ),
        .req_dm_i   (bus.I_DM_REQ),
        .grant_en_i (arb_en),
        .valid_o    (arb_valid),
        .pick_o     (arb_pick)
    );

    // Next-state and datapath decisions for the three-state access sequencer.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        arb_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    arb_en  = 1'b1;
                    grant_d = arb_pick;
                    state_d = ACCESS;
                    if (arb_pick == REQ_DM) begin
                        mem_addr_d = bus.I_DM_ADDR;
                        mem_data_d = bus.I_DM_WDATA;
                        mem_we_d   = bus.I_DM_WE;
                    end else begin
                        // Fetch is read-only; write data bus left as is.
                        mem_addr_d = bus.I_IF_ADDR;
                        mem_we_d   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                // RAM sampled the held bus on the falling edge; its read data is valid now.
                mem_we_d = 1'b0;
                state_d  = DONE;
                if (grant_q == REQ_IF) begin
                    if_data_d = bus.I_MEM_DATA;
                    if_ack_d  = 1'b1;
                end else begin
                    dm_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.I_MEM_DATA;
                    end
                end
            end
            DONE: begin
                // Ack is visible this cycle; requests seen here are handled from IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q    <= IDLE;
            grant_q    <= REQ_IF;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.O_IF_ACK   = if_ack_q;
    assign bus.O_IF_DATA  = if_data_q;
    assign bus.O_DM_ACK   = dm_ack_q;
    assign bus.O_DM_RDATA = dm_rdata_q;
    assign bus.O_MEM_WE   = mem_we_q;
    assign bus.O_MEM_ADDR = mem_addr_q;
    assign bus.O_MEM_DATA = mem_data_q;
    assign bus.O_BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance with a
// falling-edge RAM model and a scoreboard of expected ack data, plus a
// fixed-priority instance checked on its ack pattern.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus2 ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN(1'b1)) u_dut (
        .I_CLK   (clk),
        .I_RST_N (rst_n),
        .bus     (bus)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN(1'b0)) u_dut_fp (
        .I_CLK   (clk),
        .I_RST_N (rst2_n),
        .bus     (bus2)
    );

    // RAM model: unwritten words hold a fixed pattern, RAM[3] = 0x8301.
    bit          written [65536];
    logic [15:0] wval    [65536];

    function automatic logic [15:0] ram_init(input logic [15:0] a);
        if (a == 16'h0003) return 16'h8301;
        return {~a[7:0], a[7:0]};
    endfunction

    function automatic logic [15:0] ram_peek(input logic [15:0] a);
        return written[a] ? wval[a] : ram_init(a);
    endfunction

    always @(negedge clk) begin
        bus.I_MEM_DATA <= ram_peek(bus.O_MEM_ADDR);
        if (bus.O_MEM_WE) begin
            written[bus.O_MEM_ADDR] <= 1'b1;
            wval[bus.O_MEM_ADDR]    <= bus.O_MEM_DATA;
        end
    end

    always @(negedge clk) begin
        bus2.I_MEM_DATA <= ~bus2.O_MEM_ADDR;
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] if_q [$];
    logic [15:0] dm_q [$];
    logic [15:0] exp_dm;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic push_if(input logic [15:0] d);
        if_q.push_back(d);
    endtask

    task automatic push_dm_load(input logic [15:0] d);
        dm_q.push_back(d);
        exp_dm = d;
    endtask

    task automatic push_dm_store();
        dm_q.push_back(exp_dm);
    endtask

    // One clock: sample after the edge, retire acks against the scoreboard.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.O_IF_ACK) begin
            if (if_q.size() == 0) chk("if_spurious_ack", bus.O_IF_ACK, 1'b0);
            else begin
                logic [15:0] e;
                e = if_q.pop_front();
                chk16("if_ack_data", bus.O_IF_DATA, e);
                $display("txn: IF ack data=0x%04h", bus.O_IF_DATA);
            end
        end
        if (bus.O_DM_ACK) begin
            if (dm_q.size() == 0) chk("dm_spurious_ack", bus.O_DM_ACK, 1'b0);
            else begin
                logic [15:0] e;
                e = dm_q.pop_front();
                chk16("dm_ack_rdata", bus.O_DM_RDATA, e);
                $display("txn: DM ack rdata=0x%04h", bus.O_DM_RDATA);
            end
        end
        if (bus.O_MEM_WE) begin
            chk("we_only_in_access_busy", bus.O_BUSY, 1'b1);
            chk("we_only_in_access_noack", bus.O_IF_ACK | bus.O_DM_ACK, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},     bus.O_BUSY,     1'b0);
        chk({tag, "_if_ack"},   bus.O_IF_ACK,   1'b0);
        chk({tag, "_dm_ack"},   bus.O_DM_ACK,   1'b0);
        chk({tag, "_mem_we"},   bus.O_MEM_WE,   1'b0);
        chk16({tag, "_mem_addr"}, bus.O_MEM_ADDR, 16'h0000);
        chk16({tag, "_mem_data"}, bus.O_MEM_DATA, 16'h0000);
        chk16({tag, "_if_data"},  bus.O_IF_DATA,  16'h0000);
        chk16({tag, "_dm_rdata"}, bus.O_DM_RDATA, 16'h0000);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        rst2_n = 1'b0;
        bus.I_IF_REQ = 1'b0;  bus.I_IF_ADDR = '0;
        bus.I_DM_REQ = 1'b0;  bus.I_DM_WE = 1'b0;
        bus.I_DM_ADDR = '0;   bus.I_DM_WDATA = '0;
        bus2.I_IF_REQ = 1'b0; bus2.I_IF_ADDR = '0;
        bus2.I_DM_REQ = 1'b0; bus2.I_DM_WE = 1'b0;
        bus2.I_DM_ADDR = '0;  bus2.I_DM_WDATA = '0;
        exp_dm = '0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Single fetch of RAM[3], request already up when reset is released mid-cycle.
        bus.I_IF_REQ = 1'b1;
        bus.I_IF_ADDR = 16'h0003;
        push_if(16'h8301);
        #3 rst_n = 1'b1;
        cyc();
        chk("fetch_first_edge_busy", bus.O_BUSY, 1'b1);
        chk16("fetch_mem_addr", bus.O_MEM_ADDR, 16'h0003);
        chk("fetch_mem_we", bus.O_MEM_WE, 1'b0);
        chk("fetch_ack_early", bus.O_IF_ACK, 1'b0);
        cyc();
        chk("fetch_ack", bus.O_IF_ACK, 1'b1);
        chk("fetch_dm_ack", bus.O_DM_ACK, 1'b0);
        chk16("fetch_data", bus.O_IF_DATA, 16'h8301);
        chk("fetch_we_done", bus.O_MEM_WE, 1'b0);
        bus.I_IF_REQ = 1'b0;
        cyc();
        chk("fetch_ack_pulse", bus.O_IF_ACK, 1'b0);
        chk("fetch_idle", bus.O_BUSY, 1'b0);
        chk16("fetch_data_held", bus.O_IF_DATA, 16'h8301);

        // Store 0xBEEF to 7, then load it back; request stays up through DONE.
        bus.I_DM_REQ = 1'b1;
        bus.I_DM_WE = 1'b1;
        bus.I_DM_ADDR = 16'h0007;
        bus.I_DM_WDATA = 16'hBEEF;
        push_dm_store();
        cyc();
        chk("store_mem_we", bus.O_MEM_WE, 1'b1);
        chk16("store_mem_addr", bus.O_MEM_ADDR, 16'h0007);
        chk16("store_mem_data", bus.O_MEM_DATA, 16'hBEEF);
        cyc();
        chk("store_ack", bus.O_DM_ACK, 1'b1);
        chk("store_we_dropped", bus.O_MEM_WE, 1'b0);
        chk16("store_rdata_kept", bus.O_DM_RDATA, 16'h0000);
        bus.I_DM_WE = 1'b0;
        push_dm_load(16'hBEEF);
        cyc();
        chk("load_gap_ack", bus.O_DM_ACK, 1'b0);
        chk("load_gap_idle", bus.O_BUSY, 1'b0);
        cyc();
        chk("load_busy", bus.O_BUSY, 1'b1);
        chk("load_mem_we", bus.O_MEM_WE, 1'b0);
        cyc();
        chk("load_ack", bus.O_DM_ACK, 1'b1);
        chk16("load_rdata", bus.O_DM_RDATA, 16'hBEEF);
        chk("store_ram_written", written[16'h0007], 1'b1);
        chk16("store_ram_value", wval[16'h0007], 16'hBEEF);
        bus.I_DM_REQ = 1'b0;
        cyc();

        // Fetch request dropped during ACCESS still completes once.
        bus.I_IF_REQ = 1'b1;
        bus.I_IF_ADDR = 16'h0005;
        push_if(ram_init(16'h0005));
        cyc();
        bus.I_IF_REQ = 1'b0;
        chk("drop_busy", bus.O_BUSY, 1'b1);
        cyc();
        chk("drop_ack", bus.O_IF_ACK, 1'b1);
        cyc();
        chk("drop_ack_pulse", bus.O_IF_ACK, 1'b0);
        cyc();
        chk("drop_no_reaccess_a", bus.O_BUSY, 1'b0);
        cyc();
        chk("drop_no_reaccess_b", bus.O_BUSY, 1'b0);

        // Round-robin contention: last grant was fetch, so DM, IF, DM, IF.
        bus.I_IF_ADDR = 16'h0003;
        bus.I_DM_ADDR = 16'h0007;
        bus.I_DM_WE = 1'b0;
        bus.I_IF_REQ = 1'b1;
        bus.I_DM_REQ = 1'b1;
        push_dm_load(16'hBEEF);
        push_dm_load(16'hBEEF);
        push_if(16'h8301);
        push_if(16'h8301);
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk($sformatf("rr_dm_ack_k%0d", k), bus.O_DM_ACK, (k % 6) == 1);
            chk($sformatf("rr_if_ack_k%0d", k), bus.O_IF_ACK, (k % 6) == 4);
            if (k == 10) begin
                bus.I_IF_REQ = 1'b0;
                bus.I_DM_REQ = 1'b0;
            end
        end
        chk("rr_if_all_served", if_q.size() == 0, 1'b1);
        chk("rr_dm_all_served", dm_q.size() == 0, 1'b1);

        // Reset lands in ACCESS of a store before the RAM falling edge.
        bus.I_DM_REQ = 1'b1;
        bus.I_DM_WE = 1'b1;
        bus.I_DM_ADDR = 16'h0002;
        bus.I_DM_WDATA = 16'h1234;
        cyc();
        chk("abort_we_before_reset", bus.O_MEM_WE, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        bus.I_DM_REQ = 1'b0;
        bus.I_DM_WE = 1'b0;
        exp_dm = '0;
        cyc();
        cyc();
        chk("abort_no_dm_ack", bus.O_DM_ACK, 1'b0);
        chk("abort_ram_untouched", written[16'h0002], 1'b0);
        rst_n = 1'b1;
        bus.I_DM_REQ = 1'b1;
        bus.I_DM_ADDR = 16'h0002;
        push_dm_load(ram_init(16'h0002));
        cyc();
        cyc();
        chk("abort_reload_ack", bus.O_DM_ACK, 1'b1);
        chk16("abort_reload_data", bus.O_DM_RDATA, ram_init(16'h0002));
        bus.I_DM_REQ = 1'b0;
        cyc();

        // Fixed priority: DM every 3 cycles, IF starved until DM releases.
        rst2_n = 1'b1;
        bus2.I_IF_ADDR = 16'h0011;
        bus2.I_DM_ADDR = 16'h0022;
        bus2.I_IF_REQ = 1'b1;
        bus2.I_DM_REQ = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cyc();
            chk($sformatf("fp_dm_ack_k%0d", k), bus2.O_DM_ACK, ((k % 3) == 1) && (k <= 10));
            chk($sformatf("fp_if_ack_k%0d", k), bus2.O_IF_ACK, k == 13);
            if (bus2.O_IF_ACK) $display("txn: FP IF ack at k=%0d", k);
            if (bus2.O_DM_ACK) $display("txn: FP DM ack at k=%0d", k);
            if (k == 10) bus2.I_DM_REQ = 1'b0;
            if (k == 13) chk("fp_if_we_low", bus2.O_MEM_WE, 1'b0);
        end
        bus2.I_IF_REQ = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, shall set the width of every address port.
REQ-002 Parameter DATA_W, default 16, shall set the width of every data port.
REQ-003 Parameter RR_EN, default 1, shall select the policy: 1 = round-robin, 0 = fixed priority with data port over fetch port.
REQ-004 I_CLK  in  1  single clock; all state shall change on its rising edge.
REQ-005 I_RST_N  in  1  reset, asynchronous, active-low.
REQ-006 I_IF_REQ  in  1  fetch port read request.
REQ-007 I_IF_ADDR  in  ADDR_W  fetch address.
REQ-008 O_IF_ACK  out  1  one-cycle pulse; fetch access complete.
REQ-009 O_IF_DATA  out  DATA_W  fetched word; valid while O_IF_ACK=1 and held until the next fetch ack.
REQ-010 I_DM_REQ  in  1  data port request.
REQ-011 I_DM_WE  in  1  data port write enable: 1 = store, 0 = load.
REQ-012 I_DM_ADDR  in  ADDR_W  data address.
REQ-013 I_DM_WDATA  in  DATA_W  store data.
REQ-014 O_DM_ACK  out  1  one-cycle pulse; data access complete.
REQ-015 O_DM_RDATA  out  DATA_W  load data; valid while O_DM_ACK=1 and held until the next data ack.
REQ-016 O_MEM_WE  out  1  RAM write enable.
REQ-017 O_MEM_ADDR  out  ADDR_W  RAM address.
REQ-018 O_MEM_DATA  out  DATA_W  RAM write data.
REQ-019 I_MEM_DATA  in  DATA_W  RAM read data; the RAM captures on the falling edge of I_CLK.
REQ-020 O_BUSY  out  1  high whenever the FSM is not in IDLE.

Function
REQ-021 The FSM shall have exactly three states: IDLE, ACCESS, DONE.
REQ-022 In IDLE, when either request is high at a rising edge, the block shall grant one port, register its address, write data and write enable onto the O_MEM_* ports, and go to ACCESS.
REQ-023 In ACCESS, the block shall hold the O_MEM_* ports stable for one full cycle so the RAM falling edge samples them, capture I_MEM_DATA at the next rising edge, drop O_MEM_WE, and go to DONE.
REQ-024 In DONE, the block shall pulse the granted port's ACK for exactly one cycle, then return to IDLE.
REQ-025 Latency shall be fixed: ACK is high in the third cycle after the cycle in which REQ is first sampled high; the maximum throughput is one access per 3 cycles.
REQ-026 Round-robin: with both requests high in IDLE, the block shall grant the port not granted most recently; the pointer shall reset to "fetch last", so the data port wins the first tie.
REQ-027 Fixed priority (RR_EN=0): the data port shall always win a tie.
REQ-028 The fetch port shall be read-only; O_MEM_WE shall be 0 for every fetch grant.
REQ-029 Requesters shall hold REQ, ADDR, WE and WDATA until ACK. If REQ drops after grant, the access shall still complete and ACK shall still pulse.
REQ-030 A request that stays high in the DONE cycle shall be treated as a new request in the following IDLE.
REQ-031 The losing requester shall wait without loss; its ACK shall stay 0 until it is served.
REQ-032 O_MEM_WE shall never be high outside ACCESS.
REQ-033 For a store, O_DM_RDATA shall keep its previous value.
REQ-034 Addresses shall pass through unmodified with no wrap or range check; out-of-range handling belongs to the RAM.

Reset
REQ-035 On I_RST_N=0, asynchronously: state = IDLE; O_MEM_WE = 0; O_MEM_ADDR, O_MEM_DATA, O_IF_DATA and O_DM_RDATA = 0; both ACKs = 0; O_BUSY = 0; round-robin pointer = fetch-last.
REQ-036 Reset asserted during ACCESS shall abort the access with no ACK; a write that was in flight shall be dropped if reset lands before the RAM falling edge.
REQ-037 The first request shall be accepted at the first rising edge after I_RST_N deasserts.

Structure
REQ-038 A shared package shall hold the state enum (IDLE/ACCESS/DONE), the requester ID constants (REQ_IF=0, REQ_DM=1) and the default widths of 16.
REQ-039 The block shall contain one sub-module, rr_arb2: a 2-way combinational pick with a registered last-grant pointer, which honours RR_EN.

Verification
REQ-040 Single fetch: I_IF_REQ=1, addr 0x0003, RAM[3]=0x8301 -> O_IF_ACK in cycle 3, O_IF_DATA=0x8301, O_MEM_WE stays 0.
REQ-041 Store then load: DM write 0x0007 <= 0xBEEF, then DM read 0x0007 -> two acks 3 cycles apart, O_DM_RDATA=0xBEEF.
REQ-042 Contention, RR_EN=1, both requesting continuously -> grants alternate DM, IF, DM, IF; each ACK pulses every 6 cycles.
REQ-043 Contention, RR_EN=0, both requesting continuously -> DM is served every 3 cycles and IF is never acked; release DM -> IF acked 3 cycles later.
REQ-044 Reset mid-ACCESS of a DM write 0x0002 <= 0x1234 asserted before the falling edge -> no ACK, RAM[2] unchanged, all outputs 0.
REQ-045 REQ dropped in ACCESS -> ACK still pulses once; no second access follows.
